// File: rtl/xcvr245_bus_ctrl.sv
// xcvr245_bus_ctrl: A-side controller for an octal '245-style bidirectional
// transceiver. It turns single-beat read/write requests into a sequence of
// dir / nOE / A-drive controls. Guard cycles cover the transceiver's enable
// and propagation delays. dir never changes, and A is never released, while
// the transceiver is enabled.
//
// Sequence for one transfer: IDLE -> SETUP (1) -> ACTIVE (SETTLE_CYCLES)
//                            -> RECOVER (TURN_CYCLES) -> IDLE
//
// Handshake: a request is accepted on a rising edge where
// req_valid && req_ready. req_ready is high only in IDLE. rsp_valid is a
// one-cycle pulse with no backpressure, issued on re-entry to IDLE.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_write, req_wdata  request direction (1 = A->B) and write data
//   rsp_valid, rsp_rdata  completion pulse; last read data (held)
//   xcvr_dir, xcvr_noe    transceiver direction and active-low enable
//   a_out, a_oe           A-side drive value and tri-state enable
//   a_in                  sampled A-side value
//   busy                  high whenever the controller is not in IDLE
module xcvr245_bus_ctrl #(
    parameter int DATA_W        = 8,
    parameter int SETTLE_CYCLES = 2,
    parameter int TURN_CYCLES   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              xcvr_dir,
    output logic              xcvr_noe,
    output logic [DATA_W-1:0] a_out,
    output logic              a_oe,
    input  logic [DATA_W-1:0] a_in,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETUP   = 2'd1;
    localparam logic [1:0] ST_ACTIVE  = 2'd2;
    localparam logic [1:0] ST_RECOVER = 2'd3;

    localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES);
    localparam logic [7:0] TURN_LD   = 8'(TURN_CYCLES);

    logic [1:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic              dir_q, dir_d;
    logic              noe_q, noe_d;
    logic              a_oe_q, a_oe_d;
    logic [DATA_W-1:0] a_out_q, a_out_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;

    // Every output is a flop. Each output's next value is computed together
    // with the next state, so the outputs line up with the state they belong to.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        dir_d       = dir_q;
        noe_d       = noe_q;
        a_oe_d      = a_oe_q;
        a_out_d     = a_out_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;

        case (state_q)
            ST_IDLE: begin
                // ready_q is high exactly in IDLE, so this is the accept edge.
                if (req_valid && ready_q) begin
                    state_d = ST_SETUP;
                    wr_d    = req_write;
                    dir_d   = req_write;
                    noe_d   = 1'b1;
                    a_oe_d  = req_write;
                    if (req_write) begin
                        a_out_d = req_wdata;
                    end
                end
            end
            ST_SETUP: begin
                // dir and the A drive have had a full cycle to settle.
                // The transceiver can be enabled now.
                state_d = ST_ACTIVE;
                noe_d   = 1'b0;
                cnt_d   = SETTLE_LD;
            end
            ST_ACTIVE: begin
                if (cnt_q == 8'd1) begin
                    state_d = ST_RECOVER;
                    noe_d   = 1'b1;
                    cnt_d   = TURN_LD;
                    // The only edge on which A is sampled for a read.
                    if (!wr_q) begin
                        rdata_d = a_in;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_RECOVER: begin
                // A stays driven until nOE has been high for TURN_CYCLES.
                if (cnt_q == 8'd1) begin
                    state_d     = ST_IDLE;
                    a_oe_d      = 1'b0;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                noe_d   = 1'b1;
                a_oe_d  = 1'b0;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            wr_q        <= 1'b0;
            dir_q       <= 1'b1;
            noe_q       <= 1'b1;
            a_oe_q      <= 1'b0;
            a_out_q     <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            dir_q       <= dir_d;
            noe_q       <= noe_d;
            a_oe_q      <= a_oe_d;
            a_out_q     <= a_out_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign xcvr_dir  = dir_q;
    assign xcvr_noe  = noe_q;
    assign a_out     = a_out_q;
    assign a_oe      = a_oe_q;

    // A reset abort legitimately drops a_oe and forces dir while nOE is low.
    // The bus checks below therefore skip the cycle that follows a reset.
    logic rst_seen_q;
    always_ff @(posedge clk) begin
        rst_seen_q <= reset;
    end

    // dir may move only after nOE has been high for at least one cycle.
    a_dir_guard: assert property (@(posedge clk) disable iff (reset || rst_seen_q)
        (xcvr_dir != $past(xcvr_dir)) |-> (xcvr_noe && $past(xcvr_noe)));

    // A and the transceiver must never both drive the A side.
    a_no_contention: assert property (@(posedge clk) disable iff (reset || rst_seen_q)
        !(a_oe && !xcvr_dir && !xcvr_noe));

    a_release_safe: assert property (@(posedge clk) disable iff (reset || rst_seen_q)
        $fell(a_oe) |-> xcvr_noe);

endmodule

// File: tb/tb_xcvr245_bus_ctrl.sv
// Bench for xcvr245_bus_ctrl. The main instance uses the default timing
// (SETTLE=2, TURN=1). A second instance uses SETTLE=4, TURN=3 to check
// parameterised latency. The expected waveform of each transfer comes from
// the cycle offset after the accept edge, using the documented phase lengths.
module tb_xcvr245_bus_ctrl;

    localparam int S  = 2;
    localparam int T  = 1;
    localparam int L  = 2 + S + T;
    localparam int S2 = 4;
    localparam int T2 = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid, req_ready, req_write;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       xcvr_dir, xcvr_noe, a_oe, busy;
    logic [7:0] a_out, a_in;

    logic       r2_valid, r2_ready, r2_write, r2_rsp_valid;
    logic       r2_dir, r2_noe, r2_a_oe, r2_busy;
    logic [7:0] r2_wdata, r2_rdata, r2_a_out, r2_a_in;

    // B-side value driven by the transceiver model, plus junk seen on A
    // whenever the transceiver is not driving A.
    logic [7:0] b_drive, b2_drive, junk;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_rdata;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    always @(negedge clk) junk = 8'($urandom);

    assign a_in    = (!xcvr_noe && !xcvr_dir) ? b_drive : junk;
    assign r2_a_in = (!r2_noe && !r2_dir) ? b2_drive : junk;

    xcvr245_bus_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .xcvr_dir(xcvr_dir), .xcvr_noe(xcvr_noe),
        .a_out(a_out), .a_oe(a_oe), .a_in(a_in), .busy(busy)
    );

    xcvr245_bus_ctrl #(.DATA_W(8), .SETTLE_CYCLES(S2), .TURN_CYCLES(T2)) dut2 (
        .clk(clk), .reset(reset),
        .req_valid(r2_valid), .req_ready(r2_ready),
        .req_write(r2_write), .req_wdata(r2_wdata),
        .rsp_valid(r2_rsp_valid), .rsp_rdata(r2_rdata),
        .xcvr_dir(r2_dir), .xcvr_noe(r2_noe),
        .a_out(r2_a_out), .a_oe(r2_a_oe), .a_in(r2_a_in), .busy(r2_busy)
    );

    // Runs one transfer on the main instance. Call it at a negedge where
    // the controller is ready: idle, or in the previous transfer's rsp cycle.
    // It returns at the negedge of this transfer's rsp_valid cycle.
    task automatic do_xfer(input logic wr, input logic [7:0] data, input logic [7:0] bval);
        logic [5:0] exp_v, got_v;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_at_start: req_ready=%b expected 1", req_ready);
        end
        req_valid = 1'b1;
        req_write = wr;
        req_wdata = data;
        b_drive   = bval;
        if (!wr) exp_q.push_back(bval);
        for (int k = 1; k <= L; k++) begin
            @(negedge clk);
            if (k == 1) begin
                // Scrambled request fields must be ignored outside the accept cycle.
                req_valid = 1'b0;
                req_write = 1'($urandom);
                req_wdata = 8'($urandom);
            end
            exp_v = {~(k >= 2 && k <= S + 1), wr, wr && (k <= S + T + 1),
                     k == L, k == L, k != L};
            got_v = {xcvr_noe, xcvr_dir, a_oe, rsp_valid, req_ready, busy};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL xfer_ctrl wr=%b k=%0d: {noe,dir,aoe,rsp,rdy,busy}=%b expected %b",
                         wr, k, got_v, exp_v);
            end
            if (wr && k < L) begin
                checks++;
                if (a_out !== data) begin
                    errors++;
                    $display("FAIL write_a_out k=%0d: a_out=%h expected %h", k, a_out, data);
                end
            end
            if (k == L) begin
                if (!wr) exp_rdata = exp_q.pop_front();
                checks++;
                if (rsp_rdata !== exp_rdata) begin
                    errors++;
                    $display("FAIL rsp_rdata wr=%b: rsp_rdata=%h expected %h", wr, rsp_rdata, exp_rdata);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({xcvr_noe, xcvr_dir, a_oe, rsp_valid, req_ready, busy, rsp_rdata, a_out}
            !== {6'b110010, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL reset_state: noe=%b dir=%b aoe=%b rsp=%b rdy=%b busy=%b rdata=%h a_out=%h expected 1 1 0 0 1 0 00 00",
                     xcvr_noe, xcvr_dir, a_oe, rsp_valid, req_ready, busy, rsp_rdata, a_out);
        end
        reset = 1'b0;
        exp_rdata = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        do_xfer(1'b1, 8'hFF, 8'h00);
        @(negedge clk);
        do_xfer(1'b0, 8'h00, 8'h5A);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        do_xfer(1'b1, 8'hFF, 8'h77);
        do_xfer(1'b0, 8'h11, 8'h00);
        do_xfer(1'b0, 8'h22, 8'hC3);
        do_xfer(1'b1, 8'h0F, 8'h99);
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            do_xfer(1'($urandom), 8'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_active();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_wdata = 8'hA5;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (xcvr_noe !== 1'b0) begin
            errors++;
            $display("FAIL abort_in_active: noe=%b expected 0", xcvr_noe);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_rdata = 8'h00;
        checks++;
        if ({xcvr_noe, xcvr_dir, a_oe, rsp_valid, busy, rsp_rdata} !== {5'b11000, 8'h00}) begin
            errors++;
            $display("FAIL reset_abort: noe=%b dir=%b aoe=%b rsp=%b busy=%b rdata=%h expected 1 1 0 0 0 00",
                     xcvr_noe, xcvr_dir, a_oe, rsp_valid, busy, rsp_rdata);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_rsp cycle %0d: rsp_valid=%b expected 0", i, rsp_valid);
            end
        end
        do_xfer(1'b0, 8'h00, 8'h3C);
        @(negedge clk);
    endtask

    task automatic test_reset_with_req();
        reset     = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_wdata = 8'hEE;
        @(negedge clk);
        reset     = 1'b0;
        req_valid = 1'b0;
        checks++;
        if ({busy, a_oe, req_ready} !== 3'b001) begin
            errors++;
            $display("FAIL reset_with_req: busy=%b aoe=%b rdy=%b expected 0 0 1", busy, a_oe, req_ready);
        end
        @(negedge clk);
        checks++;
        if ({busy, a_oe, xcvr_noe} !== 3'b001) begin
            errors++;
            $display("FAIL reset_with_req_after: busy=%b aoe=%b noe=%b expected 0 0 1", busy, a_oe, xcvr_noe);
        end
    endtask

    task automatic test_long_timing();
        int lat;
        int noe_low;
        for (int r = 0; r < 3; r++) begin
            b2_drive = 8'($urandom);
            r2_valid = 1'b1;
            r2_write = 1'b0;
            r2_wdata = 8'($urandom);
            lat      = 0;
            noe_low  = 0;
            do begin
                @(negedge clk);
                r2_valid = 1'b0;
                lat++;
                if (!r2_noe) noe_low++;
            end while (!r2_rsp_valid && lat < 40);
            checks++;
            if (lat !== 2 + S2 + T2) begin
                errors++;
                $display("FAIL long_latency: latency=%0d expected %0d", lat, 2 + S2 + T2);
            end
            checks++;
            if (noe_low !== S2) begin
                errors++;
                $display("FAIL long_noe_low: noe low %0d cycles expected %0d", noe_low, S2);
            end
            checks++;
            if (r2_rdata !== b2_drive) begin
                errors++;
                $display("FAIL long_rdata: rdata=%h expected %h", r2_rdata, b2_drive);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_wdata = 8'h00;
        b_drive   = 8'h00;
        r2_valid  = 1'b0;
        r2_write  = 1'b0;
        r2_wdata  = 8'h00;
        b2_drive  = 8'h00;
        exp_rdata = 8'h00;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_back_to_back();
        test_random();
        test_reset_mid_active();
        test_reset_with_req();
        test_long_timing();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
